// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the NOP encoding used to fill an empty IF/ID register, default reset and
// exception-vector PCs, and small PC helper functions.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_e;

   // sll $0,$0,0 -- the canonical MIPS NOP
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_0800;

   // Sequential successor; wraps modulo 2^32.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Instruction fetches are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
//   imem_req   master->slave  request; held high until imem_ack
//   imem_addr  master->slave  word-aligned byte address
//   imem_ack   slave->master  imem_rdata valid this cycle
//   imem_rdata slave->master  instruction word
// Handshake: a transfer completes in every cycle where imem_req && imem_ack.
// Once imem_req rises it stays high, with imem_addr stable, until that cycle;
// imem_ack may be asserted in the very cycle imem_req first rises. At most one
// request is ever outstanding.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_rdata);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry {ir, pc} holding buffer for an instruction word that returned from
// memory while decode was stalled.
//   clk, rst   clock, asynchronous active-high reset
//   load_i     capture ir_i/pc_i and mark full
//   clear_i    mark empty (wins over load_i)
//   ir_i, pc_i word and its address to capture
//   full_o     buffer holds a word
//   ir_o, pc_o buffered word and address
// -----------------------------------------------------------------------------
module fetch_skid_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] ir_i,
   input  logic [31:0] pc_i,
   output logic        full_o,
   output logic [31:0] ir_o,
   output logic [31:0] pc_o
);

   logic        full_q;
   logic [31:0] ir_q;
   logic [31:0] pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         ir_q   <= 32'h0;
         pc_q   <= 32'h0;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q <= 1'b1;
         ir_q   <= ir_i;
         pc_q   <= pc_i;
      end
   end

   assign full_o = full_q;
   assign ir_o   = ir_q;
   assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, runs the
// req/ack handshake to instruction memory, parks one returned word in a skid
// buffer while decode stalls, and applies redirects and the exception vector.
//   clk, rst        clock, asynchronous active-high reset
//   imem            instruction-memory bus (master side)
//   stall           decode cannot accept; IF/ID holds
//   redirect_valid  taken branch/jump/jr/eret; target redirect_pc (word aligned)
//   exc_valid       exception/syscall; target EXC_VEC; beats redirect_valid
//   id_valid        id_ir holds a real instruction
//   id_ir           instruction (NOP when not valid)
//   id_pc, id_pc4   address of id_ir and that address + 4
//   dbg_state_o     current FSM state
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_stage_if.master        imem,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   input  logic                 exc_valid,
   output logic                 id_valid,
   output logic [31:0]          id_ir,
   output logic [31:0]          id_pc,
   output logic [31:0]          id_pc4,
   output fetch_state_e         dbg_state_o
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;        // next instruction to fetch (or the redirect target)
   logic [31:0]  addr_q;      // address on the bus; differs from pc_q only in DISCARD
   logic         req_q;
   logic         id_valid_q;
   logic [31:0]  id_ir_q;
   logic [31:0]  id_pc_q;
   logic [31:0]  id_pc4_q;

   logic         redir;
   logic [31:0]  target_pc;
   logic [31:0]  pc_seq;
   logic         skid_load;
   logic         skid_clear;
   logic         skid_full;
   logic [31:0]  skid_ir;
   logic [31:0]  skid_pc;

   assign redir     = exc_valid | redirect_valid;
   assign target_pc = exc_valid ? EXC_VEC : word_align(redirect_pc);
   assign pc_seq    = pc_plus4(pc_q);

   // A word that arrives while decode is stalled is parked; the skid empties
   // on release or is thrown away by any redirect.
   assign skid_load  = (state_q == ST_REQ) & imem.imem_ack & stall & ~redir;
   assign skid_clear = redir | ((state_q == ST_HOLD) & ~stall);

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .ir_i    (imem.imem_rdata),
      .pc_i    (pc_q),
      .full_o  (skid_full),
      .ir_o    (skid_ir),
      .pc_o    (skid_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         id_valid_q <= 1'b0;
         id_ir_q    <= NOP_INSTR;
         id_pc_q    <= 32'h0;
         id_pc4_q   <= 32'h0;
      end else if (redir) begin
         id_valid_q <= 1'b0;
         id_ir_q    <= NOP_INSTR;
         pc_q       <= target_pc;
         req_q      <= 1'b1;
         // An unanswered request cannot be withdrawn: keep presenting the old
         // address and drop its data when it finally arrives.
         if ((state_q == ST_REQ || state_q == ST_DISCARD) && !imem.imem_ack) begin
            state_q <= ST_DISCARD;
         end else begin
            state_q <= ST_REQ;
            addr_q  <= target_pc;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_REQ;
               req_q   <= 1'b1;
               addr_q  <= pc_q;
            end
            ST_REQ: begin
               if (imem.imem_ack) begin
                  if (stall) begin
                     state_q <= ST_HOLD;
                     req_q   <= 1'b0;
                  end else begin
                     id_valid_q <= 1'b1;
                     id_ir_q    <= imem.imem_rdata;
                     id_pc_q    <= pc_q;
                     id_pc4_q   <= pc_seq;
                     pc_q       <= pc_seq;
                     addr_q     <= pc_seq;
                  end
               end else if (!stall) begin
                  id_valid_q <= 1'b0;
                  id_ir_q    <= NOP_INSTR;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  id_valid_q <= skid_full;
                  id_ir_q    <= skid_ir;
                  id_pc_q    <= skid_pc;
                  id_pc4_q   <= pc_plus4(skid_pc);
                  pc_q       <= pc_seq;
                  addr_q     <= pc_seq;
                  state_q    <= ST_REQ;
                  req_q      <= 1'b1;
               end
            end
            ST_DISCARD: begin
               if (imem.imem_ack) begin
                  state_q <= ST_REQ;
                  addr_q  <= pc_q;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign id_valid       = id_valid_q;
   assign id_ir          = id_ir_q;
   assign id_pc          = id_pc_q;
   assign id_pc4         = id_pc4_q;
   assign dbg_state_o    = state_q;

endmodule
